// File: rtl/soc_region_table.sv
// Runtime-programmable address-region table: software fills a shadow table
// through a req/gnt port, a commit copies it atomically into the active table,
// and a one-register lookup pipe decodes addresses against the active table.

// One rule: shadow/active register pair plus its range comparator.
module soc_region_rule #(
    parameter int unsigned          AddrWidth = 64,
    parameter logic [AddrWidth-1:0] RstBase   = '0,
    parameter logic [AddrWidth-1:0] RstLength = '0,
    parameter logic [3:0]           RstAttr   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_base_i,
    input  logic                 we_len_i,
    input  logic                 we_attr_i,
    input  logic                 commit_i,
    input  logic [AddrWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] lu_addr_i,
    output logic [AddrWidth-1:0] sh_base_o,
    output logic [AddrWidth-1:0] sh_len_o,
    output logic [3:0]           sh_attr_o,
    output logic [3:0]           attr_o,
    output logic                 match_o
);
    logic [AddrWidth-1:0] sh_base_q, sh_len_q, base_q, len_q;
    logic [3:0]           sh_attr_q, attr_q;
    logic [AddrWidth:0]   end_excl;

    // Shadow takes software writes; active copies the whole shadow on commit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_base_q <= RstBase;
            sh_len_q  <= RstLength;
            sh_attr_q <= RstAttr;
            base_q    <= RstBase;
            len_q     <= RstLength;
            attr_q    <= RstAttr;
        end else begin
            if (we_base_i) sh_base_q <= wdata_i;
            if (we_len_i)  sh_len_q  <= wdata_i;
            if (we_attr_i) sh_attr_q <= wdata_i[3:0];
            if (commit_i) begin
                base_q <= sh_base_q;
                len_q  <= sh_len_q;
                attr_q <= sh_attr_q;
            end
        end
    end

    // One extra bit so a region ending exactly at 2^AddrWidth still covers its top address
    assign end_excl  = {1'b0, base_q} + {1'b0, len_q};
    assign match_o   = attr_q[0] && (len_q != '0) && (lu_addr_i >= base_q) &&
                       ({1'b0, lu_addr_i} < end_excl);
    assign sh_base_o = sh_base_q;
    assign sh_len_o  = sh_len_q;
    assign sh_attr_o = sh_attr_q;
    assign attr_o    = attr_q;
endmodule

module soc_region_table #(
    parameter int unsigned                        NrRules   = 4,
    parameter int unsigned                        AddrWidth = 64,
    parameter logic [NrRules-1:0][AddrWidth-1:0]  RstBase   = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0]  RstLength = '0,
    parameter logic [NrRules-1:0][3:0]            RstAttr   = '0,
    parameter int unsigned                        CfgAW     = $clog2(3*NrRules+1),
    localparam int unsigned                       IdxW      = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [CfgAW-1:0]     cfg_addr_i,
    input  logic [63:0]          cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [63:0]          cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lu_valid_i,
    output logic                 lu_ready_o,
    input  logic [AddrWidth-1:0] lu_addr_i,
    output logic                 lu_valid_o,
    input  logic                 lu_ready_i,
    output logic [IdxW-1:0]      lu_idx_o,
    output logic [3:0]           lu_attr_o,
    output logic                 lu_miss_o
);
    localparam logic [CfgAW-1:0] CtrlAddr = CfgAW'(3*NrRules);

    logic                               lock_q, dirty_q, cfg_rvalid_q, cfg_err_q;
    logic [63:0]                        cfg_rdata_q, rdata_d;
    logic                               lu_valid_q, lu_miss_q;
    logic [IdxW-1:0]                    lu_idx_q, idx_d;
    logic [3:0]                         lu_attr_q, attr_d;
    logic [NrRules-1:0][AddrWidth-1:0]  sh_base, sh_len;
    logic [NrRules-1:0][3:0]            sh_attr, act_attr;
    logic [NrRules-1:0]                 match, we_base, we_len, we_attr;
    logic                               wr_ok, addr_bad, ctrl_sel, commit, rule_wr, err_d, hit;

    assign cfg_gnt_o = cfg_req_i;
    // A locked table swallows every write; the error response reports it
    assign wr_ok    = cfg_req_i && cfg_we_i && !lock_q;
    assign addr_bad = cfg_addr_i > CtrlAddr;
    assign ctrl_sel = cfg_addr_i == CtrlAddr;
    assign commit   = wr_ok && ctrl_sel && cfg_wdata_i[0];
    assign rule_wr  = |{we_base, we_len, we_attr};

    for (genvar r = 0; r < NrRules; r++) begin : g_rule
        assign we_base[r] = wr_ok && (cfg_addr_i == CfgAW'(3*r));
        assign we_len[r]  = wr_ok && (cfg_addr_i == CfgAW'(3*r+1));
        assign we_attr[r] = wr_ok && (cfg_addr_i == CfgAW'(3*r+2));
        soc_region_rule #(
            .AddrWidth (AddrWidth),
            .RstBase   (RstBase[r]),
            .RstLength (RstLength[r]),
            .RstAttr   (RstAttr[r])
        ) u_rule (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .we_base_i (we_base[r]),
            .we_len_i  (we_len[r]),
            .we_attr_i (we_attr[r]),
            .commit_i  (commit),
            .wdata_i   (cfg_wdata_i[AddrWidth-1:0]),
            .lu_addr_i (lu_addr_i),
            .sh_base_o (sh_base[r]),
            .sh_len_o  (sh_len[r]),
            .sh_attr_o (sh_attr[r]),
            .attr_o    (act_attr[r]),
            .match_o   (match[r])
        );
    end

    // Config read mux over the shadow table and CTRL; writes and bad addresses return zero
    always_comb begin
        rdata_d = '0;
        err_d   = addr_bad || (cfg_we_i && lock_q);
        if (!cfg_we_i && !addr_bad) begin
            if (ctrl_sel) rdata_d = {61'b0, dirty_q, lock_q, 1'b0};
            for (int r = 0; r < int'(NrRules); r++) begin
                if (cfg_addr_i == CfgAW'(3*r))   rdata_d = 64'(sh_base[r]);
                if (cfg_addr_i == CfgAW'(3*r+1)) rdata_d = 64'(sh_len[r]);
                if (cfg_addr_i == CfgAW'(3*r+2)) rdata_d = {60'b0, sh_attr[r]};
            end
        end
    end

    // Config response register plus the sticky lock and dirty flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
            cfg_err_q    <= 1'b0;
            lock_q       <= 1'b0;
            dirty_q      <= 1'b0;
        end else begin
            cfg_rvalid_q <= cfg_req_i;
            cfg_rdata_q  <= cfg_req_i ? rdata_d : '0;
            cfg_err_q    <= cfg_req_i && err_d;
            if (wr_ok && ctrl_sel && cfg_wdata_i[1]) lock_q <= 1'b1;
            if (commit)       dirty_q <= 1'b0;
            else if (rule_wr) dirty_q <= 1'b1;
        end
    end

    // Priority encode: scanning downward leaves the lowest matching rule in place
    always_comb begin
        hit    = 1'b0;
        idx_d  = '0;
        attr_d = '0;
        for (int r = int'(NrRules) - 1; r >= 0; r--) begin
            if (match[r]) begin
                hit    = 1'b1;
                idx_d  = IdxW'(r);
                attr_d = act_attr[r];
            end
        end
    end

    assign lu_ready_o = !lu_valid_q || lu_ready_i;

    // Single output register; holds while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lu_valid_q <= 1'b0;
            lu_idx_q   <= '0;
            lu_attr_q  <= '0;
            lu_miss_q  <= 1'b0;
        end else if (lu_ready_o) begin
            lu_valid_q <= lu_valid_i;
            if (lu_valid_i) begin
                lu_idx_q  <= idx_d;
                lu_attr_q <= attr_d;
                lu_miss_q <= !hit;
            end
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign cfg_err_o    = cfg_err_q;
    assign lu_valid_o   = lu_valid_q;
    assign lu_idx_o     = lu_idx_q;
    assign lu_attr_o    = lu_attr_q;
    assign lu_miss_o    = lu_miss_q;
endmodule

// File: tb/tb_soc_region_table.sv
// Bench for soc_region_table: config transactions checked inline per scenario,
// lookup results checked against a queue of expectations by a monitor.
module tb_soc_region_table;
    localparam logic [3:0][63:0] RB = {64'h0, 64'h0, 64'h0, 64'h8000_0000};
    localparam logic [3:0][63:0] RL = {64'h0, 64'h0, 64'h0, 64'h4000_0000};
    localparam logic [3:0][3:0]  RA = {4'h0, 4'h0, 4'h0, 4'h7};

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] attr;
        logic       miss;
    } lu_exp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cfg_req_i = 1'b0, cfg_we_i = 1'b0;
    logic [3:0]  cfg_addr_i = '0;
    logic [63:0] cfg_wdata_i = '0;
    logic        cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
    logic [63:0] cfg_rdata_o;
    logic        lu_valid_i = 1'b0, lu_ready_i = 1'b1;
    logic [63:0] lu_addr_i = '0;
    logic        lu_ready_o, lu_valid_o, lu_miss_o;
    logic [1:0]  lu_idx_o;
    logic [3:0]  lu_attr_o;

    int checks = 0;
    int errors = 0;
    lu_exp_t exp_q[$];
    lu_exp_t mon_e;

    soc_region_table #(
        .NrRules(4), .AddrWidth(64), .RstBase(RB), .RstLength(RL), .RstAttr(RA)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
        .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_addr_i(lu_addr_i),
        .lu_valid_o(lu_valid_o), .lu_ready_i(lu_ready_i), .lu_idx_o(lu_idx_o),
        .lu_attr_o(lu_attr_o), .lu_miss_o(lu_miss_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every consumed result must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_ni && lu_valid_o && lu_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lu_unexpected: got idx=%0d attr=%h miss=%b with no result outstanding",
                         lu_idx_o, lu_attr_o, lu_miss_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({lu_idx_o, lu_attr_o, lu_miss_o} !== mon_e) begin
                    errors++;
                    $display("FAIL lu_result: got idx=%0d attr=%h miss=%b, expected idx=%0d attr=%h miss=%b",
                             lu_idx_o, lu_attr_o, lu_miss_o, mon_e.idx, mon_e.attr, mon_e.miss);
                end
            end
        end
    end

    // All tasks start and end just after a rising edge
    task automatic cfg_xfer(input logic we, input logic [3:0] addr, input logic [63:0] wd,
                            output logic [63:0] rd, output logic err);
        cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd;
        #1;
        checks++;
        if (cfg_gnt_o !== 1'b1) begin
            errors++; $display("FAIL cfg_gnt: got %b, expected 1", cfg_gnt_o);
        end
        @(posedge clk); #1;
        cfg_req_i = 1'b0; cfg_we_i = 1'b0;
        checks++;
        if (cfg_rvalid_o !== 1'b1) begin
            errors++; $display("FAIL cfg_rvalid: got %b, expected 1 one cycle after grant", cfg_rvalid_o);
        end
        rd = cfg_rdata_o; err = cfg_err_o;
        @(posedge clk); #1;
        checks++;
        if (cfg_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL cfg_rvalid_pulse: got %b, expected 0", cfg_rvalid_o);
        end
    endtask

    task automatic lookup(input logic [63:0] a, input logic [1:0] idx, input logic [3:0] attr,
                          input logic miss);
        exp_q.push_back({idx, attr, miss});
        lu_valid_i = 1'b1; lu_addr_i = a;
        @(posedge clk); #1;
    endtask

    task automatic lu_drain();
        int n = 0;
        lu_valid_i = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL lu_drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [63:0] rd; logic er;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({lu_valid_o, lu_idx_o, lu_attr_o, lu_miss_o, cfg_rvalid_o, cfg_err_o, cfg_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got lu v=%b i=%0d a=%h m=%b cfg v=%b e=%b d=%h, expected all 0",
                     lu_valid_o, lu_idx_o, lu_attr_o, lu_miss_o, cfg_rvalid_o, cfg_err_o, cfg_rdata_o);
        end
        checks++;
        if (lu_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, expected 1", lu_ready_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        cfg_xfer(1'b0, 4'd12, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h0}) begin
            errors++; $display("FAIL reset_ctrl: got err=%b data=%h, expected err=0 data=0", er, rd);
        end
        cfg_xfer(1'b0, 4'd0, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h8000_0000}) begin
            errors++; $display("FAIL reset_base0: got err=%b data=%h, expected 80000000", er, rd);
        end
        cfg_xfer(1'b0, 4'd2, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h7}) begin
            errors++; $display("FAIL reset_attr0: got err=%b data=%h, expected 7", er, rd);
        end
        lookup(64'hBFFF_FFFF, 2'd0, 4'h7, 1'b0);
        lookup(64'hC000_0000, 2'd0, 4'h0, 1'b1);
        lookup(64'h7FFF_FFFF, 2'd0, 4'h0, 1'b1);
        lu_drain();
    endtask

    task automatic test_overlap();
        logic [63:0] rd; logic er;
        logic [3:0]  wa [7] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};
        logic [63:0] wd [7] = '{64'h1000, 64'h1000, 64'h1, 64'h0, 64'h10000, 64'h1, 64'h1};
        for (int i = 0; i < 7; i++) begin
            cfg_xfer(1'b1, wa[i], wd[i], rd, er);
            checks++;
            if ({er, rd} !== {1'b0, 64'h0}) begin
                errors++; $display("FAIL overlap_wr%0d: got err=%b data=%h, expected 0/0", i, er, rd);
            end
        end
        lookup(64'h1800, 2'd1, 4'h1, 1'b0);
        lookup(64'h2000, 2'd2, 4'h1, 1'b0);
        lookup(64'h0, 2'd2, 4'h1, 1'b0);
        lookup(64'h1FFF, 2'd1, 4'h1, 1'b0);
        lookup(64'h10000, 2'd0, 4'h0, 1'b1);
        lu_drain();
    endtask

    task automatic test_commit();
        logic [63:0] rd; logic er;
        cfg_xfer(1'b1, 4'd9, 64'h2000_0000, rd, er);
        cfg_xfer(1'b1, 4'd10, 64'h80_0000, rd, er);
        cfg_xfer(1'b1, 4'd11, 64'h1, rd, er);
        lookup(64'h2000_0000, 2'd0, 4'h0, 1'b1);
        lu_drain();
        cfg_xfer(1'b0, 4'd12, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h4}) begin
            errors++; $display("FAIL commit_dirty: got err=%b data=%h, expected 4", er, rd);
        end
        cfg_xfer(1'b0, 4'd10, '0, rd, er);
        checks++;
        if (rd !== 64'h80_0000) begin
            errors++; $display("FAIL commit_shadow_len: got %h, expected 800000", rd);
        end
        // Commit grant and a lookup in the same cycle: lookup sees the old table
        cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 4'd12; cfg_wdata_i = 64'h1;
        exp_q.push_back({2'd0, 4'h0, 1'b1});
        lu_valid_i = 1'b1; lu_addr_i = 64'h2000_0000;
        @(posedge clk); #1;
        cfg_req_i = 1'b0; cfg_we_i = 1'b0;
        checks++;
        if ({cfg_rvalid_o, cfg_err_o} !== 2'b10) begin
            errors++; $display("FAIL commit_resp: got rvalid=%b err=%b, expected 1/0", cfg_rvalid_o, cfg_err_o);
        end
        lookup(64'h2000_0000, 2'd3, 4'h1, 1'b0);
        lookup(64'h207F_FFFF, 2'd3, 4'h1, 1'b0);
        lookup(64'h2080_0000, 2'd0, 4'h0, 1'b1);
        lu_drain();
        cfg_xfer(1'b0, 4'd12, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h0}) begin
            errors++; $display("FAIL commit_clean: got err=%b data=%h, expected 0", er, rd);
        end
    endtask

    task automatic test_backpressure();
        lu_ready_i = 1'b0;
        lookup(64'h1800, 2'd1, 4'h1, 1'b0);
        exp_q.push_back({2'd2, 4'h1, 1'b0});
        lu_addr_i = 64'h2000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({lu_valid_o, lu_idx_o, lu_attr_o, lu_miss_o} !== {1'b1, 2'd1, 4'h1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b idx=%0d attr=%h miss=%b, expected 1/1/1/0",
                         i, lu_valid_o, lu_idx_o, lu_attr_o, lu_miss_o);
            end
            checks++;
            if (lu_ready_o !== 1'b0) begin
                errors++; $display("FAIL bp_ready%0d: got %b, expected 0", i, lu_ready_o);
            end
            @(posedge clk); #1;
        end
        lu_ready_i = 1'b1;
        @(posedge clk); #1;
        lookup(64'h2000_0000, 2'd3, 4'h1, 1'b0);
        lookup(64'hC000_0000, 2'd0, 4'h0, 1'b1);
        lookup(64'h8000_0000, 2'd0, 4'h7, 1'b0);
        lu_drain();
    endtask

    task automatic test_top();
        logic [63:0] rd; logic er;
        cfg_xfer(1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_F000, rd, er);
        cfg_xfer(1'b1, 4'd10, 64'h1000, rd, er);
        cfg_xfer(1'b1, 4'd11, 64'hB, rd, er);
        cfg_xfer(1'b0, 4'd12, '0, rd, er);
        checks++;
        if (rd !== 64'h4) begin
            errors++; $display("FAIL top_dirty: got %h, expected 4", rd);
        end
        cfg_xfer(1'b1, 4'd12, 64'h1, rd, er);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 4'hB, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_F000, 2'd3, 4'hB, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_EFFF, 2'd0, 4'h0, 1'b1);
        lu_drain();
    endtask

    task automatic test_lock();
        logic [63:0] rd; logic er;
        cfg_xfer(1'b1, 4'd12, 64'h2, rd, er);
        checks++;
        if (er !== 1'b0) begin
            errors++; $display("FAIL lock_set: got err=%b, expected 0", er);
        end
        cfg_xfer(1'b1, 4'd0, 64'h0, rd, er);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL lock_wr_err: got err=%b, expected 1", er);
        end
        cfg_xfer(1'b0, 4'd0, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h8000_0000}) begin
            errors++; $display("FAIL lock_readback: got err=%b data=%h, expected 0/80000000", er, rd);
        end
        cfg_xfer(1'b1, 4'd5, 64'h0, rd, er);
        cfg_xfer(1'b1, 4'd12, 64'h1, rd, er);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL lock_commit_err: got err=%b, expected 1", er);
        end
        cfg_xfer(1'b0, 4'd12, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h2}) begin
            errors++; $display("FAIL lock_ctrl: got err=%b data=%h, expected 0/2", er, rd);
        end
        lookup(64'hBFFF_FFFF, 2'd0, 4'h7, 1'b0);
        lookup(64'h1800, 2'd1, 4'h1, 1'b0);
        lu_drain();
        cfg_xfer(1'b0, 4'd13, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b1, 64'h0}) begin
            errors++; $display("FAIL bad_addr13: got err=%b data=%h, expected 1/0", er, rd);
        end
        cfg_xfer(1'b0, 4'd15, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b1, 64'h0}) begin
            errors++; $display("FAIL bad_addr15: got err=%b data=%h, expected 1/0", er, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er;
        lookup(64'h1800, 2'd1, 4'h1, 1'b0);
        lookup(64'h2000, 2'd2, 4'h1, 1'b0);
        lu_addr_i = 64'hFFFF_FFFF_FFFF_FFFF;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({lu_valid_o, lu_idx_o, lu_attr_o, lu_miss_o} !== '0) begin
            errors++;
            $display("FAIL midrst_out: got v=%b idx=%0d attr=%h miss=%b, expected all 0",
                     lu_valid_o, lu_idx_o, lu_attr_o, lu_miss_o);
        end
        exp_q.delete();
        lu_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        cfg_xfer(1'b0, 4'd12, '0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, 64'h0}) begin
            errors++; $display("FAIL midrst_ctrl: got err=%b data=%h, expected 0/0", er, rd);
        end
        lookup(64'h1800, 2'd0, 4'h0, 1'b1);
        lookup(64'h8000_0000, 2'd0, 4'h7, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 4'h0, 1'b1);
        lu_drain();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_commit();
        test_backpressure();
        test_top();
        test_lock();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish before 500000");
        $fatal(1, "timeout");
    end
endmodule
